mps_relay_sequencer: RTL and testbench

Downstream consumer of the MPS operation FSM state codes. Decodes the on-sequence and off-sequence state codes into external relay/contactor commands on `o_ext_do`. Enforces break-before-make dead time between the discharge relay and the charge-path relays (slow-charge, main). Monitors relay feedback on `i_ext_di` and latches per-relay faults.

---
 rtl/mps_relay_pkg.sv | 60 ++++++
 rtl/mps_relay_sequencer_if.sv | 18 +
 rtl/relay_fb_monitor.sv | 50 +++++
 rtl/mps_relay_sequencer.sv | 146 ++++++++++++++
 tb/tb_mps_relay_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mps_relay_pkg.sv
// mps_relay_pkg: shared definitions for the MPS relay sequencer.
//   - on/off sequence state codes produced by the upstream operation FSM
//   - relay bit indices into the ext DO/DI words
//   - sequencer FSM encoding and the target decode helper
package mps_relay_pkg;

  localparam logic [3:0] ON_IDLE          = 4'd0;
  localparam logic [3:0] ON_CLR           = 4'd1;
  localparam logic [3:0] ON_DISCHA_CHK    = 4'd4;
  localparam logic [3:0] ON_DISCHA_DONE   = 4'd5;
  localparam logic [3:0] ON_SLOW_ON       = 4'd6;
  localparam logic [3:0] ON_SLOW_ON_DONE  = 4'd7;
  localparam logic [3:0] ON_DC            = 4'd8;
  localparam logic [3:0] ON_DC_DONE       = 4'd9;
  localparam logic [3:0] ON_MAIN          = 4'd10;
  localparam logic [3:0] ON_MAIN_DONE     = 4'd11;
  localparam logic [3:0] ON_SLOW_OFF      = 4'd12;
  localparam logic [3:0] ON_SLOW_OFF_DONE = 4'd13;
  localparam logic [3:0] ON_SYSTEM_ON     = 4'd14;
  localparam logic [3:0] ON_FAIL          = 4'd15;

  localparam logic [3:0] OFF_IDLE         = 4'd0;
  localparam logic [3:0] OFF_MAIN_OFF     = 4'd1;
  localparam logic [3:0] OFF_DISCHA_ON    = 4'd2;
  localparam logic [3:0] OFF_SYSTEM_OFF   = 4'd3;

  localparam int REL_DC     = 0;
  localparam int REL_MAIN   = 1;
  localparam int REL_SLOW   = 2;
  localparam int REL_DIS    = 3;
  localparam int NUM_RELAYS = 4;

  typedef enum logic [1:0] {
    S_DIS    = 2'd0,
    S_GAP_UP = 2'd1,
    S_CHG    = 2'd2,
    S_GAP_DN = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic dis;
    logic slow;
    logic main;
    logic dc;
  } relay_tgt_t;

  // Undefined codes fall through the range compares like any other value.
  function automatic relay_tgt_t decode_targets(input logic [3:0] on_s,
                                                input logic [3:0] off_s);
    relay_tgt_t t;
    t.dis  = (on_s == ON_IDLE) || (on_s == ON_CLR) || (on_s == ON_FAIL) ||
             (off_s == OFF_DISCHA_ON) || (off_s == OFF_SYSTEM_OFF);
    t.slow = (on_s >= ON_SLOW_ON) && (on_s <= ON_MAIN_DONE);
    t.main = (on_s >= ON_MAIN) && (on_s <= ON_SYSTEM_ON) && (off_s == OFF_IDLE);
    t.dc   = (on_s >= ON_DC) && (on_s <= ON_SYSTEM_ON) &&
             ((off_s == OFF_IDLE) || (off_s == OFF_MAIN_OFF));
    return t;
  endfunction

endpackage

// File: rtl/mps_relay_sequencer_if.sv
// mps_relay_sequencer_if: state-code inputs, relay feedback and relay
// command/status outputs of the sequencer.
//   master: upstream FSM + plant side (drives codes and feedback)
//   slave : the sequencer
interface mps_relay_sequencer_if;
  logic [3:0]  i_on_state;
  logic [3:0]  i_off_state;
  logic [15:0] i_ext_di;
  logic [15:0] o_ext_do;
  logic [3:0]  o_relay_fault;
  logic [1:0]  o_seq_state;
  logic        o_busy;

  modport master (output i_on_state, i_off_state, i_ext_di,
                  input  o_ext_do, o_relay_fault, o_seq_state, o_busy);
  modport slave  (input  i_on_state, i_off_state, i_ext_di,
                  output o_ext_do, o_relay_fault, o_seq_state, o_busy);
endinterface

// File: rtl/relay_fb_monitor.sv
// relay_fb_monitor: one-bit relay feedback checker.
//   i_clk, i_rst (async, active-low)
//   i_clr   : synchronous clear of counter and fault
//   i_do    : commanded relay state
//   i_di    : relay feedback
//   o_fault : sticky, set after FB_TIMEOUT continuous mismatch cycles
module relay_fb_monitor
  import mps_relay_pkg::*;
#(
  parameter int unsigned FB_TIMEOUT = 5_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_do,
  input  logic i_di,
  output logic o_fault
);
  localparam logic [31:0] CNT_LAST = 32'(FB_TIMEOUT - 1);

  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (i_clr) begin
      cnt_d   = '0;
      fault_d = 1'b0;
    end else if (i_do != i_di) begin
      // Counter parks at the last value; the fault stays set from there on.
      if (cnt_q == CNT_LAST) fault_d = 1'b1;
      else                   cnt_d   = cnt_q + 32'd1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign o_fault = fault_q;
endmodule

// File: rtl/mps_relay_sequencer.sv
// mps_relay_sequencer: decodes on/off sequence codes into relay commands
// with break-before-make dead time between the discharge relay and the
// charge-path relays (slow, main).
//   i_clk, i_rst (async, active-low)
//   bus.i_on_state/i_off_state : upstream state codes
//   bus.i_ext_di               : relay feedback (bits 3:0)
//   bus.o_ext_do               : relay commands (bits 15:4 zero)
//   bus.o_relay_fault          : sticky feedback faults
//   bus.o_seq_state, o_busy    : debug / gap indication
// Optional: RELAY_FB_CHECK_EN adds per-relay feedback monitors.
module mps_relay_sequencer
  import mps_relay_pkg::*;
#(
  parameter int unsigned DEAD_CYC   = 1000,
  parameter int unsigned FB_TIMEOUT = 5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mps_relay_sequencer_if.slave  bus
);
  localparam logic [23:0] GAP_LAST = 24'(DEAD_CYC - 1);

  relay_tgt_t tgt;
  logic       fail;
  logic       gap_done;

  seq_state_e state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  do_q, do_d;
  logic        busy_q, busy_d;
  logic [3:0]  fault;

  assign tgt      = decode_targets(bus.i_on_state, bus.i_off_state);
  assign fail     = (bus.i_on_state == ON_FAIL);
  assign gap_done = (cnt_q == GAP_LAST);

  // FAIL forces dis_t, so the normal drop path already sends S_CHG and
  // S_GAP_UP to S_GAP_DN and lets S_GAP_DN keep counting.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    do_d          = do_q;
    do_d[REL_DC]  = tgt.dc & ~fail;
    unique case (state_q)
      S_DIS: begin
        do_d[REL_DIS]  = 1'b1;
        do_d[REL_MAIN] = 1'b0;
        do_d[REL_SLOW] = 1'b0;
        if (!tgt.dis) begin
          do_d[REL_DIS] = 1'b0;
          cnt_d         = '0;
          state_d       = S_GAP_UP;
        end
      end
      S_GAP_UP: begin
        do_d[3:1] = '0;
        if (tgt.dis) begin
          cnt_d   = '0;
          state_d = S_GAP_DN;
        end else if (gap_done) begin
          // Close on the transition edge so the gap is exactly DEAD_CYC.
          do_d[REL_MAIN] = tgt.main;
          do_d[REL_SLOW] = tgt.slow;
          state_d        = S_CHG;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_CHG: begin
        do_d[REL_DIS] = 1'b0;
        if (tgt.dis) begin
          do_d[REL_MAIN] = 1'b0;
          do_d[REL_SLOW] = 1'b0;
          cnt_d          = '0;
          state_d        = S_GAP_DN;
        end else begin
          do_d[REL_MAIN] = tgt.main;
          do_d[REL_SLOW] = tgt.slow;
        end
      end
      S_GAP_DN: begin
        do_d[3:1] = '0;
        if (!tgt.dis) begin
          cnt_d   = '0;
          state_d = S_GAP_UP;
        end else if (gap_done) begin
          do_d[REL_DIS] = 1'b1;
          state_d       = S_DIS;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        do_d[3:1] = '0;
        cnt_d     = '0;
        state_d   = S_GAP_DN;
      end
    endcase
    busy_d = (state_d == S_GAP_UP) || (state_d == S_GAP_DN);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_GAP_DN;
      cnt_q   <= '0;
      do_q    <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_ext_do    = {12'b0, do_q};
  assign bus.o_seq_state = state_q;
  assign bus.o_busy      = busy_q;

  logic unused_di_hi;
  assign unused_di_hi = ^bus.i_ext_di[15:4];

`ifdef RELAY_FB_CHECK_EN
  logic fb_clr;
  assign fb_clr = (bus.i_on_state == ON_CLR);

  for (genvar k = 0; k < NUM_RELAYS; k++) begin : g_fb
    relay_fb_monitor #(.FB_TIMEOUT(FB_TIMEOUT)) u_mon (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (fb_clr),
      .i_do    (do_q[k]),
      .i_di    (bus.i_ext_di[k]),
      .o_fault (fault[k])
    );
  end
`else
  logic        unused_di_lo;
  logic [31:0] unused_fb_timeout;
  assign unused_di_lo      = ^bus.i_ext_di[3:0];
  assign unused_fb_timeout = FB_TIMEOUT;
  assign fault             = '0;
`endif

  assign bus.o_relay_fault = fault;
endmodule

// File: tb/tb_mps_relay_sequencer.sv
// tb_mps_relay_sequencer: directed test of mps_relay_sequencer with
// DEAD_CYC = 4, FB_TIMEOUT = 8. Feedback mirrors o_ext_do one cycle late,
// with per-bit forcing through di_mask.
module tb_mps_relay_sequencer;
  logic        clk;
  logic        rst_n;
  logic [15:0] di_q;
  logic [15:0] di_mask;
  int          checks;
  int          failures;

`ifdef RELAY_FB_CHECK_EN
  localparam logic [3:0] FAULT_EXP = 4'b0010;
`else
  localparam logic [3:0] FAULT_EXP = 4'b0000;
`endif

  mps_relay_sequencer_if bus ();

  mps_relay_sequencer #(.DEAD_CYC(4), .FB_TIMEOUT(8)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) di_q <= '0;
    else        di_q <= bus.o_ext_do;
  end
  assign bus.i_ext_di = di_q & ~di_mask;

  // Break-before-make must hold on every cycle.
  always @(negedge clk) begin
    checks++;
    if (bus.o_ext_do[3] && (bus.o_ext_do[2] || bus.o_ext_do[1])) begin
      failures++;
      $display("FAIL overlap: do=%h required no dis/charge overlap", bus.o_ext_do);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {do, busy, state}
  task automatic test_reset;
    rst_n = 1'b0; bus.i_on_state = 4'd0; bus.i_off_state = 4'd0; di_mask = '0;
    tick(); tick();
    checks++;
    if ({bus.o_ext_do, bus.o_relay_fault, bus.o_busy, bus.o_seq_state} !== {16'h0, 4'h0, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL reset: do=%h flt=%h busy=%b st=%0d want 0000/0/1/3",
               bus.o_ext_do, bus.o_relay_fault, bus.o_busy, bus.o_seq_state);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({bus.o_ext_do, bus.o_busy} !== {16'h0000, 1'b1}) begin
        failures++;
        $display("FAIL reset_gap c%0d: do=%h busy=%b want 0000/1", i, bus.o_ext_do, bus.o_busy);
      end
    end
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy, bus.o_seq_state} !== {16'h0008, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_dis: do=%h busy=%b st=%0d want 0008/0/0", bus.o_ext_do, bus.o_busy, bus.o_seq_state);
    end
  endtask

  task automatic test_charge_up;
    bus.i_on_state = 4'd4;
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy, bus.o_seq_state} !== {16'h0000, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL dis_drop: do=%h busy=%b st=%0d want 0000/1/1", bus.o_ext_do, bus.o_busy, bus.o_seq_state);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      if (i == 2) bus.i_on_state = 4'd6;
      checks++;
      if (bus.o_ext_do !== 16'h0000) begin
        failures++;
        $display("FAIL gap_up c%0d: do=%h want 0000", i, bus.o_ext_do);
      end
    end
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy, bus.o_seq_state} !== {16'h0004, 1'b0, 2'd2}) begin
      failures++;
      $display("FAIL slow_on: do=%h busy=%b st=%0d want 0004/0/2", bus.o_ext_do, bus.o_busy, bus.o_seq_state);
    end
  endtask

  task automatic test_walk;
    logic [3:0]  codes [4] = '{4'd8, 4'd10, 4'd12, 4'd14};
    logic [15:0] exp   [4] = '{16'h0005, 16'h0007, 16'h0003, 16'h0003};
    for (int i = 0; i < 4; i++) begin
      bus.i_on_state = codes[i];
      tick();
      checks++;
      if (bus.o_ext_do !== exp[i]) begin
        failures++;
        $display("FAIL walk on=%0d: do=%h want %h", codes[i], bus.o_ext_do, exp[i]);
      end
    end
  endtask

  task automatic test_off_seq;
    bus.i_off_state = 4'd1;
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_seq_state} !== {16'h0001, 2'd2}) begin
      failures++;
      $display("FAIL main_off: do=%h st=%0d want 0001/2", bus.o_ext_do, bus.o_seq_state);
    end
    bus.i_off_state = 4'd2;
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy, bus.o_seq_state} !== {16'h0000, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL dc_off: do=%h busy=%b st=%0d want 0000/1/3", bus.o_ext_do, bus.o_busy, bus.o_seq_state);
    end
    // Gap is counted from the edge that entered S_GAP_DN.
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.o_ext_do !== 16'h0000) begin
        failures++;
        $display("FAIL gap_dn c%0d: do=%h want 0000", i, bus.o_ext_do);
      end
    end
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy, bus.o_seq_state} !== {16'h0008, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL dis_on: do=%h busy=%b st=%0d want 0008/0/0", bus.o_ext_do, bus.o_busy, bus.o_seq_state);
    end
    // Back into charge: dc follows immediately, main waits out the gap.
    bus.i_off_state = 4'd0;
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_seq_state} !== {16'h0001, 2'd1}) begin
      failures++;
      $display("FAIL recharge_drop: do=%h st=%0d want 0001/1", bus.o_ext_do, bus.o_seq_state);
    end
    repeat (3) tick();
    checks++;
    if (bus.o_ext_do !== 16'h0001) begin
      failures++;
      $display("FAIL recharge_gap: do=%h want 0001", bus.o_ext_do);
    end
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_seq_state} !== {16'h0003, 2'd2}) begin
      failures++;
      $display("FAIL recharge_main: do=%h st=%0d want 0003/2", bus.o_ext_do, bus.o_seq_state);
    end
  endtask

  task automatic test_fail;
    bus.i_on_state = 4'd15;
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy, bus.o_seq_state} !== {16'h0000, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL fail_drop: do=%h busy=%b st=%0d want 0000/1/3", bus.o_ext_do, bus.o_busy, bus.o_seq_state);
    end
    repeat (3) tick();
    checks++;
    if (bus.o_ext_do !== 16'h0000) begin
      failures++;
      $display("FAIL fail_gap: do=%h want 0000", bus.o_ext_do);
    end
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_seq_state} !== {16'h0008, 2'd0}) begin
      failures++;
      $display("FAIL fail_dis: do=%h st=%0d want 0008/0", bus.o_ext_do, bus.o_seq_state);
    end
  endtask

  task automatic test_fault;
    bus.i_on_state = 4'd14;
    repeat (5) tick();
    checks++;
    if (bus.o_ext_do !== 16'h0003) begin
      failures++;
      $display("FAIL fault_setup: do=%h want 0003", bus.o_ext_do);
    end
    repeat (3) tick();
    di_mask = 16'h0002;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (bus.o_relay_fault !== 4'b0000) begin
        failures++;
        $display("FAIL fault_early c%0d: flt=%b want 0000", i, bus.o_relay_fault);
      end
    end
    tick();
    checks++;
    if (bus.o_relay_fault !== FAULT_EXP) begin
      failures++;
      $display("FAIL fault_set: flt=%b want %b", bus.o_relay_fault, FAULT_EXP);
    end
    repeat (3) tick();
    di_mask = '0;
    repeat (2) tick();
    checks++;
    if ({bus.o_relay_fault, bus.o_ext_do} !== {FAULT_EXP, 16'h0003}) begin
      failures++;
      $display("FAIL fault_sticky: flt=%b do=%h want %b/0003", bus.o_relay_fault, bus.o_ext_do, FAULT_EXP);
    end
    bus.i_on_state = 4'd1;
    tick();
    checks++;
    if (bus.o_relay_fault !== 4'b0000) begin
      failures++;
      $display("FAIL fault_clr: flt=%b want 0000", bus.o_relay_fault);
    end
    tick();
    checks++;
    if (bus.o_relay_fault !== 4'b0000) begin
      failures++;
      $display("FAIL fault_clr_hold: flt=%b want 0000", bus.o_relay_fault);
    end
  endtask

  task automatic test_reset_mid;
    bus.i_on_state = 4'd14;
    repeat (5) tick();
    checks++;
    if (bus.o_ext_do !== 16'h0003) begin
      failures++;
      $display("FAIL mid_setup: do=%h want 0003", bus.o_ext_do);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_ext_do, bus.o_relay_fault, bus.o_busy, bus.o_seq_state} !== {16'h0, 4'h0, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL mid_reset: do=%h flt=%h busy=%b st=%0d want 0000/0/1/3",
               bus.o_ext_do, bus.o_relay_fault, bus.o_busy, bus.o_seq_state);
    end
    bus.i_on_state = 4'd0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy} !== {16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL mid_gap: do=%h busy=%b want 0000/1", bus.o_ext_do, bus.o_busy);
    end
    tick();
    checks++;
    if ({bus.o_ext_do, bus.o_busy} !== {16'h0008, 1'b0}) begin
      failures++;
      $display("FAIL mid_dis: do=%h busy=%b want 0008/0", bus.o_ext_do, bus.o_busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_charge_up();
    test_walk();
    test_off_seq();
    test_fail();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
